// File: rtl/map_line_clear.sv
// Line-clear engine: scans the playfield bottom-up, drops full rows, compacts
// the survivors downward, zero-fills the vacated top rows and keeps score.
module map_line_clear #(
  parameter int ROWS      = 20,
  parameter int COLS      = 10,
  parameter int CELL_W    = 5,
  parameter int SCORE_MAX = 999999
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     score_clr,
  output logic [4:0]               rd_row,
  input  logic [COLS*CELL_W-1:0]   rd_data,
  output logic                     wr_en,
  output logic [4:0]               wr_row,
  output logic [COLS*CELL_W-1:0]   wr_data,
  output logic                     busy,
  output logic                     done,
  output logic [4:0]               lines_cleared,
  output logic [19:0]              score,
  output logic [19:0]              best_score
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_EVAL, S_FILL, S_DONE} state_t;

  localparam logic [CELL_W-1:0] LOCK_MAX = CELL_W'(9);

  state_t      r_state, w_next;
  logic [4:0]  r_src, r_dst, r_k;
  logic        r_done;
  logic [4:0]  r_lines;
  logic [19:0] r_score, r_best;

  logic        w_full;
  logic [4:0]  w_k_upd;
  logic [19:0] w_points;
  logic [20:0] w_sum;
  logic [19:0] w_score_new;

  // Only locked codes 1..9 count; empty or active-piece cells keep the row.
  always_comb begin
    w_full = 1'b1;
    for (int j = 0; j < COLS; j++) begin
      if (rd_data[j*CELL_W +: CELL_W] == '0 ||
          rd_data[j*CELL_W +: CELL_W] > LOCK_MAX)
        w_full = 1'b0;
    end
  end

  assign w_k_upd = r_k + {4'd0, w_full};

  always_comb begin
    case (r_k)
      5'd0:    w_points = 20'd0;
      5'd1:    w_points = 20'd100;
      5'd2:    w_points = 20'd300;
      5'd3:    w_points = 20'd500;
      5'd4:    w_points = 20'd800;
      default: w_points = 20'd800 + 20'd200 * (20'(r_k) - 20'd4);
    endcase
  end

  assign w_sum       = {1'b0, r_score} + {1'b0, w_points};
  assign w_score_new = (w_sum > 21'(SCORE_MAX)) ? 20'(SCORE_MAX) : w_sum[19:0];

  always_ff @(posedge CLOCK_50) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = S_READ;
      S_READ: w_next = S_EVAL;
      // k is decided on the last row so a pass with nothing to fill skips FILL
      S_EVAL: if (r_src == 5'd0) w_next = (w_k_upd == 5'd0) ? S_DONE : S_FILL;
              else               w_next = S_READ;
      S_FILL: if (r_dst == 5'd0) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    rd_row  = 5'd0;
    wr_en   = 1'b0;
    wr_row  = 5'd0;
    wr_data = '0;
    case (r_state)
      S_READ: rd_row = r_src;
      S_EVAL: if (!w_full && r_dst != r_src) begin
                wr_en   = 1'b1;
                wr_row  = r_dst;
                wr_data = rd_data;
              end
      S_FILL: begin
                wr_en  = 1'b1;
                wr_row = r_dst;
              end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_src   <= 5'd0;
      r_dst   <= 5'd0;
      r_k     <= 5'd0;
      r_done  <= 1'b0;
      r_lines <= 5'd0;
      r_score <= 20'd0;
      r_best  <= 20'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (score_clr) r_score <= 20'd0;
          if (start) begin
            r_src <= 5'(ROWS-1);
            r_dst <= 5'(ROWS-1);
            r_k   <= 5'd0;
          end
        end
        S_EVAL: begin
          if (w_full) r_k   <= w_k_upd;
          else        r_dst <= r_dst - 5'd1;
          if (r_src != 5'd0) r_src <= r_src - 5'd1;
        end
        S_FILL: r_dst <= r_dst - 5'd1;
        S_DONE: begin
          r_done  <= 1'b1;
          r_lines <= r_k;
          r_score <= w_score_new;
          if (w_score_new > r_best) r_best <= w_score_new;
        end
        default: ;
      endcase
    end
  end

  assign busy          = (r_state != S_IDLE);
  assign done          = r_done;
  assign lines_cleared = r_lines;
  assign score         = r_score;
  assign best_score    = r_best;

endmodule
